// File: rtl/noc_packet_arbiter.sv
// Purpose: round-robin wormhole arbiter. It merges PORTS flit streams onto one registered output and
//   holds the grant for a whole packet. The last-flit flag is bit WIDTH-1.
// Latency: 2 cycles from a request at an idle arbiter to out_valid (1 arbitration + 1 output register).
//   Each packet spends one IDLE cycle at its start.
// Backpressure: in_ready[g] = ~out_valid | out_ready. The output register drains and refills in the
//   same cycle, so there is no bubble in ACTIVE.
// Ports:
//   clk, rst_n                     clock; asynchronous active-low reset
//   in_flit/in_valid/in_ready      per-port flit bus (port i at [i*WIDTH +: WIDTH]) with handshake
//   out_flit/out_valid/out_ready   registered output stream with handshake
module noc_packet_arbiter #(
  parameter int WIDTH = 34,
  parameter int PORTS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PORTS*WIDTH-1:0] in_flit,
  input  logic [PORTS-1:0]       in_valid,
  output logic [PORTS-1:0]       in_ready,
  output logic [WIDTH-1:0]       out_flit,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;
  // Port 0 has first priority after reset, because the search starts at last_grant + 1.
  localparam logic [GW-1:0] LAST_RST = GW'(PORTS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;
  logic [WIDTH-1:0] out_flit_q, out_flit_d;
  logic             out_valid_q, out_valid_d;

  logic [GW-1:0]    rr_pick;
  logic [GW-1:0]    pick_hi, pick_lo;
  logic             found_hi;
  logic [WIDTH-1:0] grant_flit;
  logic             grant_vld;
  logic             out_free;
  logic             in_xfer;

  // Round-robin search. Take the lowest requesting port above last_grant.
  // If there is none, wrap around and take the lowest requesting port overall.
  // The loop runs downward, so the lowest index is the last one written.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        pick_lo = GW'(i);
        if (GW'(i) > last_q) begin
          pick_hi  = GW'(i);
          found_hi = 1'b1;
        end
      end
    end
    rr_pick = found_hi ? pick_hi : pick_lo;
  end

  // Grant decode: selected flit/valid and per-port ready.
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    grant_flit = '0;
    grant_vld  = 1'b0;
    in_ready   = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q == GW'(i)) begin
        grant_flit  = in_flit[i*WIDTH +: WIDTH];
        grant_vld   = in_valid[i];
        in_ready[i] = (state_q == ACTIVE) && out_free;
      end
    end
  end

  assign in_xfer = (state_q == ACTIVE) && grant_vld && out_free;

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    out_flit_d  = out_flit_q;
    out_valid_d = out_valid_q;

    // Drain first. A transfer in the same cycle overrides this, so the register
    // refills without a bubble.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = rr_pick;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // The grant stays locked while in_valid[g] is low mid-packet (wormhole).
        if (in_xfer) begin
          out_flit_d  = grant_flit;
          out_valid_d = 1'b1;
          if (grant_flit[WIDTH-1]) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= LAST_RST;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_flit  = out_flit_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_noc_packet_arbiter.sv
// Directed bench for noc_packet_arbiter (WIDTH=34, PORTS=4).
// The table covers the basic packet flow and round-robin fairness.
// Hand-written sequences cover the wormhole hole, the output stall and reset mid-packet.
module tb_noc_packet_arbiter;

  localparam int W = 34;
  localparam int P = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [P*W-1:0] in_flit;
  logic [P-1:0]   in_valid;
  logic [P-1:0]   in_ready;
  logic [W-1:0]   out_flit;
  logic           out_valid;
  logic           out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  noc_packet_arbiter #(.WIDTH(W), .PORTS(P)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flit  (in_flit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_flit (out_flit),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    logic           rst;
    logic [P-1:0]   vld;
    logic [P*W-1:0] flits;
    logic           ordy;
    logic [P-1:0]   exp_rdy;
    logic           exp_ov;
    logic [W-1:0]   exp_of;
  } vec_t;

  vec_t vq[$];

  function automatic logic [W-1:0] fl(input logic last, input logic [31:0] d);
    return {last, 1'b0, d};
  endfunction

  function automatic logic [P*W-1:0] bus(input logic [W-1:0] f0, input logic [W-1:0] f1,
                                         input logic [W-1:0] f2, input logic [W-1:0] f3);
    return {f3, f2, f1, f0};
  endfunction

  function automatic vec_t mkv(input logic rst, input logic [P-1:0] vld, input logic [P*W-1:0] flits,
                               input logic ordy, input logic [P-1:0] rdy, input logic ov,
                               input logic [W-1:0] of);
    vec_t v;
    v.rst = rst; v.vld = vld; v.flits = flits; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_ov = ov; v.exp_of = of;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, then sample 1 time unit later.
  task automatic cyc(input logic [P-1:0] vld, input logic [P*W-1:0] fls, input logic ordy);
    @(negedge clk);
    in_valid  = vld;
    in_flit   = fls;
    out_ready = ordy;
    #1;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0; in_valid = '0; in_flit = '0; out_ready = 1'b1;
    #1;
    chk({nm, " rst ov"},  {63'd0, out_valid}, 64'd0);
    chk({nm, " rst of"},  {30'd0, out_flit},  64'd0);
    chk({nm, " rst rdy"}, {60'd0, in_ready},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a1, a2, a3, b1, q1, q2, q3, r1, s1, s2, s3, t1, t2, u1;
    logic [W-1:0] pc [4];
    logic [P*W-1:0] all4;

    rst_n = 1'b0; in_valid = '0; in_flit = '0; out_ready = 1'b1;

    a1 = fl(1'b0, 32'hA1); a2 = fl(1'b0, 32'hA2); a3 = fl(1'b1, 32'hA3); b1 = fl(1'b1, 32'hB1);
    for (int i = 0; i < 4; i++) pc[i] = fl(1'b1, 32'hC0 + i);
    all4 = bus(pc[0], pc[1], pc[2], pc[3]);

    // 3-flit packet on port 0, then a single-flit packet on port 0.
    vq.push_back(mkv(1'b0, 4'b0000, '0,               1'b1, 4'b0000, 1'b0, '0));
    vq.push_back(mkv(1'b1, 4'b0001, bus(a1,0,0,0),    1'b1, 4'b0000, 1'b0, '0));
    vq.push_back(mkv(1'b1, 4'b0001, bus(a1,0,0,0),    1'b1, 4'b0001, 1'b0, '0));
    vq.push_back(mkv(1'b1, 4'b0001, bus(a2,0,0,0),    1'b1, 4'b0001, 1'b1, a1));
    vq.push_back(mkv(1'b1, 4'b0001, bus(a3,0,0,0),    1'b1, 4'b0001, 1'b1, a2));
    vq.push_back(mkv(1'b1, 4'b0001, bus(b1,0,0,0),    1'b1, 4'b0000, 1'b1, a3)); // back in IDLE
    vq.push_back(mkv(1'b1, 4'b0001, bus(b1,0,0,0),    1'b1, 4'b0001, 1'b0, a3));
    vq.push_back(mkv(1'b1, 4'b0000, '0,               1'b1, 4'b0000, 1'b1, b1));
    vq.push_back(mkv(1'b1, 4'b0000, '0,               1'b1, 4'b0000, 1'b0, b1));
    // Reset clears the held flit, then all ports stream single-flit packets: order 0,1,2,3,0.
    vq.push_back(mkv(1'b0, 4'b1111, all4, 1'b1, 4'b0000, 1'b0, '0));
    vq.push_back(mkv(1'b1, 4'b1111, all4, 1'b1, 4'b0000, 1'b0, '0));
    vq.push_back(mkv(1'b1, 4'b1111, all4, 1'b1, 4'b0001, 1'b0, '0));
    vq.push_back(mkv(1'b1, 4'b1111, all4, 1'b1, 4'b0000, 1'b1, pc[0]));
    vq.push_back(mkv(1'b1, 4'b1111, all4, 1'b1, 4'b0010, 1'b0, pc[0]));
    vq.push_back(mkv(1'b1, 4'b1111, all4, 1'b1, 4'b0000, 1'b1, pc[1]));
    vq.push_back(mkv(1'b1, 4'b1111, all4, 1'b1, 4'b0100, 1'b0, pc[1]));
    vq.push_back(mkv(1'b1, 4'b1111, all4, 1'b1, 4'b0000, 1'b1, pc[2]));
    vq.push_back(mkv(1'b1, 4'b1111, all4, 1'b1, 4'b1000, 1'b0, pc[2]));
    vq.push_back(mkv(1'b1, 4'b1111, all4, 1'b1, 4'b0000, 1'b1, pc[3]));
    vq.push_back(mkv(1'b1, 4'b1111, all4, 1'b1, 4'b0001, 1'b0, pc[3]));
    vq.push_back(mkv(1'b1, 4'b1111, all4, 1'b1, 4'b0000, 1'b1, pc[0]));

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst; in_valid = vq[i].vld; in_flit = vq[i].flits; out_ready = vq[i].ordy;
      #1;
      chk($sformatf("row%0d in_ready", i),  {60'd0, in_ready},  {60'd0, vq[i].exp_rdy});
      chk($sformatf("row%0d out_valid", i), {63'd0, out_valid}, {63'd0, vq[i].exp_ov});
      chk($sformatf("row%0d out_flit", i),  {30'd0, out_flit},  {30'd0, vq[i].exp_of});
    end

    // Wormhole lock: port 1 pauses for 3 cycles mid-packet while port 2 waits.
    do_reset("s29");
    q1 = fl(1'b0, 32'h11); q2 = fl(1'b0, 32'h12); q3 = fl(1'b1, 32'h13); r1 = fl(1'b1, 32'h21);
    cyc(4'b0110, bus(0,q1,r1,0), 1'b1); chk("s29 arb rdy", {60'd0, in_ready}, 64'h0);
    cyc(4'b0110, bus(0,q1,r1,0), 1'b1); chk("s29 g1 rdy",  {60'd0, in_ready}, 64'h2);
    for (int c = 0; c < 3; c++) begin
      cyc(4'b0100, bus(0,q1,r1,0), 1'b1);
      chk("s29 hole rdy",  {60'd0, in_ready}, 64'h2);
      chk("s29 hole flit", {30'd0, out_flit}, {30'd0, q1});
    end
    cyc(4'b0110, bus(0,q2,r1,0), 1'b1); chk("s29 resume rdy", {60'd0, in_ready}, 64'h2);
    cyc(4'b0110, bus(0,q3,r1,0), 1'b1); chk("s29 q2 out", {30'd0, out_flit}, {30'd0, q2});
    cyc(4'b0100, bus(0,0,r1,0), 1'b1);
    chk("s29 q3 out",   {30'd0, out_flit}, {30'd0, q3});
    chk("s29 idle rdy", {60'd0, in_ready}, 64'h0);
    cyc(4'b0100, bus(0,0,r1,0), 1'b1); chk("s29 g2 rdy", {60'd0, in_ready}, 64'h4);
    cyc(4'b0000, '0, 1'b1);
    chk("s29 r1 ov",  {63'd0, out_valid}, 64'd1);
    chk("s29 r1 out", {30'd0, out_flit}, {30'd0, r1});

    // Output stall for 5 cycles, then a drain and refill with no bubble.
    do_reset("s30");
    s1 = fl(1'b0, 32'h31); s2 = fl(1'b0, 32'h32); s3 = fl(1'b1, 32'h33);
    cyc(4'b0001, bus(s1,0,0,0), 1'b1);
    cyc(4'b0001, bus(s1,0,0,0), 1'b1); chk("s30 g0 rdy", {60'd0, in_ready}, 64'h1);
    for (int c = 0; c < 5; c++) begin
      cyc(4'b0001, bus(s2,0,0,0), 1'b0);
      chk("s30 stall rdy",  {60'd0, in_ready}, 64'h0);
      chk("s30 stall ov",   {63'd0, out_valid}, 64'd1);
      chk("s30 stall flit", {30'd0, out_flit}, {30'd0, s1});
    end
    cyc(4'b0001, bus(s2,0,0,0), 1'b1); chk("s30 release rdy", {60'd0, in_ready}, 64'h1);
    cyc(4'b0001, bus(s3,0,0,0), 1'b1);
    chk("s30 nobubble ov",   {63'd0, out_valid}, 64'd1);
    chk("s30 nobubble flit", {30'd0, out_flit}, {30'd0, s2});
    cyc(4'b0000, '0, 1'b1); chk("s30 s3 out", {30'd0, out_flit}, {30'd0, s3});

    // Reset mid-packet of port 3; priority restarts at port 0.
    do_reset("s31");
    t1 = fl(1'b0, 32'h41); t2 = fl(1'b0, 32'h42); u1 = fl(1'b1, 32'h51);
    cyc(4'b1000, bus(0,0,0,t1), 1'b1);
    cyc(4'b1000, bus(0,0,0,t1), 1'b1); chk("s31 g3 rdy", {60'd0, in_ready}, 64'h8);
    cyc(4'b1000, bus(0,0,0,t2), 1'b1); chk("s31 t1 out", {30'd0, out_flit}, {30'd0, t1});
    #2 rst_n = 1'b0;
    #1;
    chk("s31 async ov",  {63'd0, out_valid}, 64'd0);
    chk("s31 async of",  {30'd0, out_flit},  64'd0);
    chk("s31 async rdy", {60'd0, in_ready},  64'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 4'b1001; in_flit = bus(u1,0,0,t2); out_ready = 1'b1;
    #1;
    chk("s31 arb rdy", {60'd0, in_ready}, 64'h0);
    cyc(4'b1001, bus(u1,0,0,t2), 1'b1); chk("s31 g0 rdy", {60'd0, in_ready}, 64'h1);
    cyc(4'b1000, bus(0,0,0,t2), 1'b1);
    chk("s31 u1 ov",  {63'd0, out_valid}, 64'd1);
    chk("s31 u1 out", {30'd0, out_flit}, {30'd0, u1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
